// File: rtl/sram_frame_init.sv
// sram_frame_init: walks every pixel of a WIDTH x HEIGHT frame and writes its fixed-point seed word to SRAM
// Ports:
//   i_Clk, i_Reset      clock, synchronous active-high reset
//   i_Start             one-cycle start request, honoured only when idle
//   i_XLookat/i_YLookat signed frame centre, sampled on an accepted start
//   i_XInc/i_YInc       signed per-column / per-row step, sampled on an accepted start
//   i_WrReady           arbiter accepts the current write
//   o_WrEn/o_WrAddr/o_WrData  write request, {row, col}, {1'b0, x field, y field}
//   o_Busy              high while setting up and writing
//   o_Done              one-cycle pulse after the last accepted write
module sram_frame_init #(
    parameter int WIDTH    = 800,
    parameter int HEIGHT   = 480,
    parameter int X_ADDR_W = 10,
    parameter int Y_ADDR_W = 9,
    parameter int ACC_W    = 18,
    parameter int XW       = 8,
    parameter int YW       = 7
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Start,
    input  logic [ACC_W-1:0]             i_XLookat,
    input  logic [ACC_W-1:0]             i_YLookat,
    input  logic [ACC_W-1:0]             i_XInc,
    input  logic [ACC_W-1:0]             i_YInc,
    input  logic                         i_WrReady,
    output logic                         o_WrEn,
    output logic [X_ADDR_W+Y_ADDR_W-1:0] o_WrAddr,
    output logic [XW+YW:0]               o_WrData,
    output logic                         o_Busy,
    output logic                         o_Done
);
    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] x_look, y_look, x_inc, y_inc;
    logic [ACC_W-1:0] x_start, acc_x, acc_y, x_setup, y_setup;
    logic [X_ADDR_W-1:0] col;
    logic [Y_ADDR_W-1:0] row;
    logic fire, last_col, last_row;

    // Unsigned arithmetic here is the same two's complement result modulo 2^ACC_W.
    assign x_setup  = x_look - x_inc * ACC_W'(WIDTH >> 1);
    assign y_setup  = y_look - y_inc * ACC_W'(HEIGHT >> 1);
    assign fire     = state == WRITE && i_WrReady;
    assign last_col = col == X_ADDR_W'(WIDTH - 1);
    assign last_row = row == Y_ADDR_W'(HEIGHT - 1);

    always_ff @(posedge i_Clk) begin
        state <= i_Reset ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (i_Start ? SETUP : IDLE) :
                   state == SETUP ? WRITE :
                   state == WRITE ? (fire && last_col && last_row ? DONE : WRITE) :
                   IDLE;
    end

    always_comb begin
        o_WrEn   = state == WRITE;
        o_Busy   = state == SETUP || state == WRITE;
        o_Done   = state == DONE;
        o_WrAddr = state == WRITE ? {row, col} : '0;
        o_WrData = state == WRITE ? {1'b0, acc_x[ACC_W-1 -: XW], acc_y[ACC_W-1 -: YW]} : '0;
    end

    // Datapath needs no reset: every output it feeds is gated by the WRITE state.
    always_ff @(posedge i_Clk) begin
        if (state == IDLE && i_Start) begin
            x_look <= i_XLookat;
            y_look <= i_YLookat;
            x_inc  <= i_XInc;
            y_inc  <= i_YInc;
        end
        if (state == SETUP) begin
            x_start <= x_setup;
            acc_x   <= x_setup;
            acc_y   <= y_setup;
            col     <= '0;
            row     <= '0;
        end
        if (fire) begin
            if (!last_col) begin
                col   <= col + X_ADDR_W'(1);
                acc_x <= acc_x + x_inc;
            end else begin
                col   <= '0;
                acc_x <= x_start;
                if (!last_row) begin
                    row   <= row + Y_ADDR_W'(1);
                    acc_y <= acc_y + y_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_frame_init.sv
// tb_sram_frame_init: directed bench comparing sram_frame_init against a direct-form pixel model
module tb_sram_frame_init;
    localparam int W = 4;
    localparam int H = 3;
    localparam int XA = 3;
    localparam int YA = 2;

    logic clk = 0;
    logic i_Reset, i_Start, i_WrReady;
    logic [17:0] i_XLookat, i_YLookat, i_XInc, i_YInc;
    logic o_WrEn, o_Busy, o_Done;
    logic [XA+YA-1:0] o_WrAddr;
    logic [15:0] o_WrData;

    int checks = 0, errors = 0, cyc = 0, t0 = 0, stalls = 0, ndone = 0;
    bit rnd = 0;
    logic [20:0] exp_q[$];

    sram_frame_init #(.WIDTH(W), .HEIGHT(H), .X_ADDR_W(XA), .Y_ADDR_W(YA),
                      .ACC_W(18), .XW(8), .YW(7)) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Start(i_Start),
        .i_XLookat(i_XLookat), .i_YLookat(i_YLookat), .i_XInc(i_XInc), .i_YInc(i_YInc),
        .i_WrReady(i_WrReady), .o_WrEn(o_WrEn), .o_WrAddr(o_WrAddr), .o_WrData(o_WrData),
        .o_Busy(o_Busy), .o_Done(o_Done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Direct form: each pixel seed derived from its row/column index, x_start + inc*index.
    task automatic build(input logic [17:0] xl, yl, xi, yi);
        logic [17:0] x, y;
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                x = xl - xi * 18'(W / 2) + xi * 18'(c);
                y = yl - yi * 18'(H / 2) + yi * 18'(r);
                exp_q.push_back({YA'(r), XA'(c), 1'b0, x[17:10], y[17:11]});
            end
    endtask

    always @(negedge clk) begin
        if (o_WrEn) begin
            if (exp_q.size() == 0) chk("unexpected_write", {11'd0, o_WrAddr, o_WrData}, 32'hFFFFFFFF);
            else begin
                chk("write", {11'd0, o_WrAddr, o_WrData}, {11'd0, exp_q[0]});
                if (i_WrReady) void'(exp_q.pop_front());
                else stalls++;
            end
        end
        if (o_Done) begin
            ndone++;
            chk("done_cycle", cyc, t0 + 2 + W * H + stalls);
            chk("done_remaining", exp_q.size(), 0);
            chk("done_busy", o_Busy, 0);
        end
    end

    initial begin
        i_WrReady = 1;
        forever begin
            @(posedge clk);
            #1 i_WrReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [17:0] xl, yl, xi, yi);
        build(xl, yl, xi, yi);
        i_XLookat = xl; i_YLookat = yl; i_XInc = xi; i_YInc = yi;
        i_Start = 1; t0 = cyc; stalls = 0;
        tick();
        i_Start = 0;
        @(negedge clk);
        chk("setup_busy", o_Busy, 1);
        chk("setup_wren", o_WrEn, 0);
    endtask

    task automatic wait_done();
        int n0 = ndone;
        int k = 0;
        while (ndone == n0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (ndone == n0) chk("done_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc != target) tick();
    endtask

    initial begin
        int n;
        i_Reset = 1; i_Start = 0;
        i_XLookat = 0; i_YLookat = 0; i_XInc = 0; i_YInc = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_wren", o_WrEn, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_done", o_Done, 0);
        chk("rst_addr", o_WrAddr, 0);
        chk("rst_data", o_WrData, 0);
        tick();
        i_Reset = 0;

        build(0, 0, 18'h00400, 18'h00400);
        chk("model_px0", exp_q[0], 21'h007F7F);
        chk("model_px3", exp_q[3], 21'h0300FF);
        chk("model_px4", exp_q[4], 21'h087F00);
        chk("model_px11", exp_q[11], 21'h130080);
        tick();
        start(0, 0, 18'h00400, 18'h00400);
        @(negedge clk);
        chk("first_wren", o_WrEn, 1);
        wait_done();

        rnd = 1;
        tick();
        start(0, 0, 18'h00400, 18'h00400);
        wait_done();
        rnd = 0;
        tick();

        build(18'h1FFFF, 18'h00123, 18'h3FC00, 18'h3FF00);
        chk("model_wrap_x0", 32'((exp_q[0] >> 7) & 21'hFF), 32'h81);
        chk("model_wrap_x3", 32'((exp_q[3] >> 7) & 21'hFF), 32'h7E);
        tick();
        start(18'h1FFFF, 18'h00123, 18'h3FC00, 18'h3FF00);
        wait_done();

        tick();
        n = ndone;
        start(0, 0, 18'h00400, 18'h00400);
        wait_cyc(t0 + 6);
        i_Reset = 1;
        tick();
        i_Reset = 0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_wren", o_WrEn, 0);
        chk("abort_busy", o_Busy, 0);
        repeat (20) tick();
        chk("abort_no_done", ndone, n);

        start(18'h00200, 18'h3FE00, 18'h00080, 18'h00100);
        @(negedge clk);
        chk("restart_addr", o_WrAddr, 0);
        wait_done();

        tick();
        n = ndone;
        start(0, 0, 18'h00400, 18'h00400);
        wait_cyc(t0 + 4);
        i_Start = 1; i_XLookat = 18'h15555; i_XInc = 18'h00001;
        tick();
        i_Start = 0;
        wait_cyc(t0 + 2 + W * H);
        i_Start = 1;
        tick();
        i_Start = 0;
        @(negedge clk);
        chk("done_start_ignored", o_Busy, 0);
        chk("one_frame", ndone, n + 1);
        tick();
        start(18'h01000, 18'h00800, 18'h3FF00, 18'h00040);
        wait_done();
        repeat (20) tick();
        chk("two_frames", ndone, n + 2);

        i_Start = 1; i_Reset = 1;
        tick();
        i_Start = 0; i_Reset = 0;
        @(negedge clk);
        chk("reset_beats_start", o_Busy, 0);
        tick();
        @(negedge clk);
        chk("reset_beats_start_wren", o_WrEn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_frame_init.md
# sram_frame_init

Sequential, parametrised frame initialiser for the Julia/Mandelbrot pixel SRAM. On a start pulse it walks every pixel address of a WIDTH x HEIGHT frame and writes each seed word: done flag clear, truncated fixed-point x0 and y0. Centre point and per-pixel increment are runtime inputs, so the host can pan and zoom without a rebuild. It sits between the frame controller and the SRAM write arbiter, and runs before the iteration engine starts.

## Interface

Parameters:
- WIDTH, 800, pixels per row
- HEIGHT, 480, rows per frame
- X_ADDR_W, 10, column address bits; must satisfy 2^X_ADDR_W >= WIDTH
- Y_ADDR_W, 9, row address bits; must satisfy 2^Y_ADDR_W >= HEIGHT
- ACC_W, 18, accumulator width: signed, 1 sign bit, 3 integer bits, ACC_W-4 fraction bits
- XW, 8, x field width; field is acc_x[ACC_W-1 -: XW]
- YW, 7, y field width; field is acc_y[ACC_W-1 -: YW]; 1+XW+YW = data width

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  one-cycle start request; ignored unless IDLE
- i_XLookat  in  ACC_W  signed centre x; sampled on accepted start
- i_YLookat  in  ACC_W  signed centre y; sampled on accepted start
- i_XInc  in  ACC_W  signed per-column step; sampled on accepted start
- i_YInc  in  ACC_W  signed per-row step; sampled on accepted start
- i_WrReady  in  1  SRAM arbiter accepts the current write
- o_WrEn  out  1  write request valid
- o_WrAddr  out  X_ADDR_W+Y_ADDR_W  {row, col}
- o_WrData  out  1+XW+YW  {1'b0, x field, y field}
- o_Busy  out  1  high in SETUP and WRITE
- o_Done  out  1  one-cycle pulse after the last accepted write

## Operation

- States: IDLE, SETUP, WRITE, DONE.
- IDLE: all outputs low. i_Start=1 latches the four runtime inputs. Next state is SETUP.
- SETUP, one cycle:
  - x_start = XLookat - XInc*(WIDTH>>1)
  - y_start = YLookat - YInc*(HEIGHT>>1)
  - acc_x <= x_start, acc_y <= y_start, col <= 0, row <= 0. Next state is WRITE.
- WRITE: o_WrEn=1. o_WrAddr = {row, col}; col is zero-extended to X_ADDR_W, so unused addresses are never written. o_WrData = {1'b0, acc_x[ACC_W-1 -: XW], acc_y[ACC_W-1 -: YW]}.
- Accepted write (o_WrEn and i_WrReady):
  - If col < WIDTH-1: col++, acc_x += XInc.
  - Else: col <= 0, acc_x <= x_start. Then if row < HEIGHT-1: row++, acc_y += YInc. Else go to DONE.
- Stall (o_WrEn and !i_WrReady): address, data and o_WrEn hold. Nothing advances.
- DONE, one cycle: o_Done=1, o_Busy=0, o_WrEn=0. Next state is IDLE.
- Arithmetic:
  - All accumulation is two's complement modulo 2^ACC_W, with no saturation.
  - The products in SETUP are truncated to ACC_W bits.
  - Fields are taken by truncation, with no rounding.
- Incremental accumulation must match the direct form x_start + XInc*col, bit-exact modulo 2^ACC_W.
- i_Start is ignored in SETUP, WRITE and DONE. Runtime inputs changing mid-run have no effect.

## Timing

- Reset values: state IDLE, o_WrEn=0, o_Busy=0, o_Done=0, o_WrAddr=0, o_WrData=0.
- Reset asserted mid-run: IDLE at the next edge. o_WrEn is low in the following cycle and no further write is issued. The partial frame is not completed.
- Latency, with i_Start sampled at edge k:
  - o_Busy high from cycle k+1 (SETUP).
  - o_WrEn high from cycle k+2.
- With i_WrReady held high:
  - One write per cycle, WIDTH*HEIGHT writes total.
  - o_Done is high in cycle k+2+WIDTH*HEIGHT.
  - IDLE again the cycle after.
- Each stall cycle extends the run by exactly one cycle.
- i_Start in the o_Done cycle is ignored. i_Start in the following IDLE cycle is accepted.
- i_Start and i_Reset both high: reset wins and the start is dropped.

## Test plan

- Defaults, XLookat=YLookat=0, XInc=YInc=18'h00074, ready high:
  - 384000 writes, in order {0,0},{0,1}…{479,799}.
  - First data = {0, (-0x74*400)[17:10], (-0x74*240)[17:11]}.
  - o_Done exactly at cycle k+2+384000.
- WIDTH=4, HEIGHT=3, Inc=18'h00400, Lookat=0:
  - 12 writes.
  - Row 0 x fields FE,FF,00,01; y field 7F.
  - Row 1 y field 00; row 2 y field 00 (0x400>>11 = 0).
  - Addresses {0,0}..{2,3}.
- Small frame with i_WrReady toggled by a random ~50% pattern:
  - Every write is held stable while stalled.
  - Sequence is identical to the ready-high run.
  - Done pulse is delayed by exactly the number of stall cycles.
- Negative step XInc=18'h3FC00 with XLookat at 18'h1FFFF:
  - Accumulator wraps modulo 2^18 and matches the direct-form model every pixel.
- i_Reset asserted on write 5 of 12:
  - o_WrEn low from the next cycle, no o_Done.
  - A later i_Start restarts from {0,0}.
- i_Start pulsed during WRITE, and again in the o_Done cycle:
  - Both ignored, with a single frame produced.
  - i_Start one cycle after o_Done starts a second frame.
